gray_cntr: RTL and testbench

Parametrised binary/Gray counter for pointer and sequence generation in the AudioNet datapath. It extends the fixed 8-bit Gray counter with:
- configurable width and reset value
- enable, up/down, and parallel load
- a registered Gray output
- a wrap indication
- a registered Gray-to-binary decoder for pointers arriving from another clock domain

It is the intended building block for async FIFO read/write pointers and frame sequence counters.

---
 rtl/gray_cntr_pkg.sv | 30 +++
 rtl/gray_cntr_if.sv | 28 ++
 rtl/gray_cntr_dec.sv | 26 ++
 rtl/gray_cntr.sv | 84 ++++++++
 tb/tb_gray_cntr.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_cntr_pkg.sv
// Shared Gray-code helpers and counter operation encoding.
// The functions work at MAX_W bits; callers zero-extend and then truncate.
package gray_pkg;

  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ALL_ONES  = '1;
  localparam logic [MAX_W-1:0] ALL_ZEROS = '0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLEAR
  } cntr_op_e;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits leave the MSB-first XOR chain unaffected, so any narrower width decodes correctly.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
    logic [MAX_W-1:0] bin;
    bin[MAX_W-1] = gray[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_cntr_if.sv
// Control, count and decode signals of gray_cntr.
// The master modport is the driving side, and the slave modport is the counter side.
interface gray_cntr_if #(
  parameter int WIDTH = 8
);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dn;
  logic [WIDTH-1:0] cntr;
  logic [WIDTH-1:0] gc;
  logic             wrap;
  logic [WIDTH-1:0] gc_in;
  logic [WIDTH-1:0] gc_in_bin;

  modport master (
    output clear, load, load_val, en, dn, gc_in,
    input  cntr, gc, wrap, gc_in_bin
  );

  modport slave (
    input  clear, load, load_val, en, dn, gc_in,
    output cntr, gc, wrap, gc_in_bin
  );

endinterface

// File: rtl/gray_cntr_dec.sv
// Registered Gray-to-binary decode of an already-synchronised remote pointer.
// It has its own reset so that FIFO status logic can reuse it.
module gray_dec
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] gc_in,
  output logic [WIDTH-1:0] gc_in_bin
);

  logic [WIDTH-1:0] gc_in_bin_comb;

  assign gc_in_bin_comb = WIDTH'(gray2bin(MAX_W'(gc_in)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gc_in_bin <= '0;
    end else begin
      gc_in_bin <= gc_in_bin_comb;
    end
  end

endmodule

// File: rtl/gray_cntr.sv
// Parametrised binary/Gray counter with load, up/down, wrap pulse and remote pointer decode.
// Defining GRAY_CNTR_SAT_EN makes the counter saturate at its ends instead of wrapping.
module gray_cntr
  import gray_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic      clk,
  input  logic      rstn,
  gray_cntr_if.slave bus
);

  localparam logic [WIDTH-1:0] ONES  = ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZEROS = ALL_ZEROS[WIDTH-1:0];

  cntr_op_e         op;
  logic [WIDTH-1:0] cntr;
  logic [WIDTH-1:0] cntr_next;
  logic [WIDTH-1:0] gc;
  logic             wrap;
  logic             wrap_next;
  logic             at_bound;

  always_comb begin
    op = OP_HOLD;
    if (bus.clear) begin
      op = OP_CLEAR;
    end else if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.en) begin
      op = OP_STEP;
    end
  end

  // A step is at the boundary when it would cross the all-ones/zero seam in the current direction.
  always_comb begin
    at_bound  = bus.dn ? (cntr == ZEROS) : (cntr == ONES);
    cntr_next = cntr;
    wrap_next = 1'b0;
    case (op)
      OP_CLEAR: cntr_next = RST_VAL;
      OP_LOAD:  cntr_next = bus.load_val;
      OP_STEP: begin
        wrap_next = at_bound;
`ifdef GRAY_CNTR_SAT_EN
        if (!at_bound) begin
          cntr_next = bus.dn ? cntr - WIDTH'(1) : cntr + WIDTH'(1);
        end
`else
        cntr_next = bus.dn ? cntr - WIDTH'(1) : cntr + WIDTH'(1);
`endif
      end
      default: cntr_next = cntr;
    endcase
  end

  // gc is encoded from the next-state value, so it shares cntr's cycle and flops cleanly without glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cntr <= RST_VAL;
      gc   <= WIDTH'(bin2gray(MAX_W'(RST_VAL)));
      wrap <= 1'b0;
    end else begin
      cntr <= cntr_next;
      gc   <= WIDTH'(bin2gray(MAX_W'(cntr_next)));
      wrap <= wrap_next;
    end
  end

  assign bus.cntr = cntr;
  assign bus.gc   = gc;
  assign bus.wrap = wrap;

  gray_dec #(
    .WIDTH(WIDTH)
  ) u_dec (
    .clk      (clk),
    .rstn     (rstn),
    .gc_in    (bus.gc_in),
    .gc_in_bin(bus.gc_in_bin)
  );

endmodule

// File: tb/tb_gray_cntr.sv
// Scoreboard bench for gray_cntr (WIDTH=8, RST_VAL=FF); it follows GRAY_CNTR_SAT_EN if defined.
module tb_gray_cntr;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  gray_cntr_if #(.WIDTH(8)) bus ();

  gray_cntr #(
    .WIDTH  (8),
    .RST_VAL(8'hFF)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] cntr;
    logic [7:0] gc;
    logic       wrap;
  } obs_t;

  obs_t       cntQ[$];
  logic [7:0] decQ[$];
  int         nCompared   = 0;
  int         nMismatched = 0;
  logic [7:0] mdl         = 8'hFF;

  function automatic logic [7:0] refGray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Brute-force inverse of refGray, which is independent of any XOR chain.
  function automatic logic [7:0] refBin(input logic [7:0] g);
    logic [7:0] r;
    r = 8'h00;
    for (int v = 0; v < 256; v++) begin
      if (refGray(8'(v)) == g) r = 8'(v);
    end
    return r;
  endfunction

  function automatic obs_t got();
    return {bus.cntr, bus.gc, bus.wrap};
  endfunction

  task automatic applyStimulus(input logic c, input logic l, input logic [7:0] lv,
                               input logic e, input logic d);
    logic       w;
    logic [7:0] nxt;
    @(negedge clk);
    bus.clear    = c;
    bus.load     = l;
    bus.load_val = lv;
    bus.en       = e;
    bus.dn       = d;
    w   = 1'b0;
    nxt = mdl;
    if (c) begin
      nxt = 8'hFF;
    end else if (l) begin
      nxt = lv;
    end else if (e) begin
      if (!d) begin
        w   = (mdl == 8'hFF);
        nxt = mdl + 8'd1;
      end else begin
        w   = (mdl == 8'h00);
        nxt = mdl - 8'd1;
      end
`ifdef GRAY_CNTR_SAT_EN
      if (w) nxt = mdl;
`endif
    end
    mdl = nxt;
    cntQ.push_back('{cntr: nxt, gc: refGray(nxt), wrap: w});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    nCompared++;
    if ({got(), bus.gc_in_bin} !== {8'hFF, 8'h80, 1'b0, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset: got cntr=%h gc=%h wrap=%b gc_in_bin=%h, expected FF/80/0/00",
               bus.cntr, bus.gc, bus.wrap, bus.gc_in_bin);
    end
    @(negedge clk);
    rstn = 1'b1;
    mdl  = 8'hFF;
  endtask

  task automatic test_count_up();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      e = cntQ.pop_front();
      nCompared++;
      if (got() !== e) begin
        nMismatched++;
        $display("[TB] FAIL count_up[%0d]: got cntr=%h gc=%h wrap=%b, expected cntr=%h gc=%h wrap=%b",
                 i, bus.cntr, bus.gc, bus.wrap, e.cntr, e.gc, e.wrap);
      end
    end
  endtask

  task automatic test_load();
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       applyStimulus(1'b0, 1'b1, 8'h7F, 1'b1, 1'b0);
        1:       applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        2:       applyStimulus(1'b1, 1'b1, 8'h12, 1'b1, 1'b0);
        default: applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      endcase
      e = cntQ.pop_front();
      nCompared++;
      if (got() !== e) begin
        nMismatched++;
        $display("[TB] FAIL load[%0d]: got cntr=%h gc=%h wrap=%b, expected cntr=%h gc=%h wrap=%b",
                 i, bus.cntr, bus.gc, bus.wrap, e.cntr, e.gc, e.wrap);
      end
    end
  endtask

  task automatic test_down_wrap();
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      else        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      e = cntQ.pop_front();
      nCompared++;
      if (got() !== e) begin
        nMismatched++;
        $display("[TB] FAIL down_wrap[%0d]: got cntr=%h gc=%h wrap=%b, expected cntr=%h gc=%h wrap=%b",
                 i, bus.cntr, bus.gc, bus.wrap, e.cntr, e.gc, e.wrap);
      end
    end
  endtask

  task automatic test_decode();
    logic [7:0] vals[8];
    logic [7:0] e;
    vals[0] = 8'hC0;
    vals[1] = 8'h80;
    vals[2] = 8'h01;
    for (int i = 3; i < 8; i++) vals[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    bus.en    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.gc_in = vals[i];
      decQ.push_back(refBin(vals[i]));
      @(posedge clk);
      #1;
      e = decQ.pop_front();
      nCompared++;
      if (bus.gc_in_bin !== e) begin
        nMismatched++;
        $display("[TB] FAIL decode gc_in=%h: got gc_in_bin=%h, expected %h",
                 vals[i], bus.gc_in_bin, e);
      end
    end
  endtask

  task automatic test_free_run();
    obs_t       e;
    logic [7:0] prevCntr;
    logic [7:0] prevGc;
    int         expDist;
    prevCntr = mdl;
    prevGc   = refGray(mdl);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, (i >= 400) ? 1'b1 : 1'b0);
      e = cntQ.pop_front();
      nCompared++;
      if (got() !== e) begin
        nMismatched++;
        $display("[TB] FAIL free_run[%0d]: got cntr=%h gc=%h wrap=%b, expected cntr=%h gc=%h wrap=%b",
                 i, bus.cntr, bus.gc, bus.wrap, e.cntr, e.gc, e.wrap);
      end
      nCompared++;
      if (bus.gc !== refGray(bus.cntr)) begin
        nMismatched++;
        $display("[TB] FAIL gc_match[%0d]: got gc=%h for cntr=%h, expected gc=%h",
                 i, bus.gc, bus.cntr, refGray(bus.cntr));
      end
      expDist = (e.cntr != prevCntr) ? 1 : 0;
      nCompared++;
      if ($countones(bus.gc ^ prevGc) != expDist) begin
        nMismatched++;
        $display("[TB] FAIL gc_hamming[%0d]: got distance %0d, expected %0d",
                 i, $countones(bus.gc ^ prevGc), expDist);
      end
      prevCntr = e.cntr;
      prevGc   = e.gc;
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    e = cntQ.pop_front();
    nCompared++;
    if (got() !== e) begin
      nMismatched++;
      $display("[TB] FAIL async_preload: got cntr=%h gc=%h wrap=%b, expected cntr=%h gc=%h wrap=%b",
               bus.cntr, bus.gc, bus.wrap, e.cntr, e.gc, e.wrap);
    end
    #2;
    rstn     = 1'b0;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    #1;
    nCompared++;
    if ({got(), bus.gc_in_bin} !== {8'hFF, 8'h80, 1'b0, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: got cntr=%h gc=%h wrap=%b gc_in_bin=%h, expected FF/80/0/00",
               bus.cntr, bus.gc, bus.wrap, bus.gc_in_bin);
    end
    @(negedge clk);
    rstn = 1'b1;
    mdl  = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      e = cntQ.pop_front();
      nCompared++;
      if (got() !== e) begin
        nMismatched++;
        $display("[TB] FAIL async_restart[%0d]: got cntr=%h gc=%h wrap=%b, expected cntr=%h gc=%h wrap=%b",
                 i, bus.cntr, bus.gc, bus.wrap, e.cntr, e.gc, e.wrap);
      end
    end
  endtask

  initial begin
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    bus.en       = 1'b0;
    bus.dn       = 1'b0;
    bus.gc_in    = 8'h00;
    $display("[TB] gray_cntr bench start");
    test_reset();
    test_count_up();
    test_load();
    test_down_wrap();
    test_decode();
    test_free_run();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
